// File: rtl/float_copro_pkg.sv
// Shared definitions for the float coprocessor arbiter: opcode encodings and
// the arbiter FSM state type.
package float_copro_pkg;

    localparam int OPW = 11;

    localparam logic [OPW-1:0] OP_ADD = 11'd0;
    localparam logic [OPW-1:0] OP_SUB = 11'd1;
    localparam logic [OPW-1:0] OP_MUL = 11'd2;
    localparam logic [OPW-1:0] OP_DIV = 11'd3;
    localparam logic [OPW-1:0] OP_MAX = OP_DIV;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching from
// ptr+1 upward with wrap, so the last winner gets lowest priority.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant = IDW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one float coprocessor between N requesters,
// with one command in flight and illegal opcodes answered locally.
module float_copro_arbiter
    import float_copro_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0][10:0]  req_opcode,
    input  logic [N-1:0][31:0]  req_op0,
    input  logic [N-1:0][31:0]  req_op1,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        rsp_valid,
    input  logic [N-1:0]        rsp_accept,
    output logic [31:0]         rsp_result,
    output logic                rsp_error,
    output logic                copro_valid,
    output logic [10:0]         copro_opcode,
    output logic [31:0]         copro_op0,
    output logic [31:0]         copro_op1,
    output logic                copro_accept,
    input  logic                copro_complete,
    input  logic [31:0]         copro_result
);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           grant_now;

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    // A completion seen in IDLE is left over from before a reset; it is
    // drained first and blocks any grant in that cycle.
    assign grant_now    = reset_n && (state == IDLE) && !copro_complete && pick_any;
    assign copro_accept = reset_n && copro_complete && ((state == IDLE) || (state == WAIT));

    always_comb begin
        req_ready = '0;
        if (grant_now) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= IDW'(N - 1);
            gnt_idx      <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_error    <= 1'b0;
            copro_valid  <= 1'b0;
            copro_opcode <= '0;
            copro_op0    <= '0;
            copro_op1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        rr_ptr  <= pick_idx;
                        gnt_idx <= pick_idx;
                        if (req_opcode[pick_idx] > OP_MAX) begin
                            rsp_valid  <= onehot(pick_idx);
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            copro_opcode <= req_opcode[pick_idx];
                            copro_op0    <= req_op0[pick_idx];
                            copro_op1    <= req_op1[pick_idx];
                            copro_valid  <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    copro_valid <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (copro_complete) begin
                        rsp_result <= copro_result;
                        rsp_error  <= 1'b0;
                        rsp_valid  <= onehot(gnt_idx);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_accept[gnt_idx]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_copro_arbiter.sv
// Scoreboard bench for float_copro_arbiter with a behavioural coprocessor
// that survives arbiter resets, so stale completions can be exercised.
module tb_float_copro_arbiter;
    import float_copro_pkg::*;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][10:0]  req_opcode;
    logic [N-1:0][31:0]  req_op0;
    logic [N-1:0][31:0]  req_op1;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_accept;
    logic [31:0]         rsp_result;
    logic                rsp_error;
    logic                copro_valid;
    logic [10:0]         copro_opcode;
    logic [31:0]         copro_op0;
    logic [31:0]         copro_op1;
    logic                copro_accept;
    logic                copro_complete = 1'b0;
    logic [31:0]         copro_result   = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   grant_q[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    int   t_ready, t_cv, t_acc, t_rsp;
    int   n_cv, n_acc, n_rv;
    bit   prev_rv = 1'b0;
    bit   seen    = 1'b0;

    int   cp_cnt  = 0;
    bit   cp_busy = 1'b0;

    float_copro_arbiter #(.N(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_opcode     (req_opcode),
        .req_op0        (req_op0),
        .req_op1        (req_op1),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_accept     (rsp_accept),
        .rsp_result     (rsp_result),
        .rsp_error      (rsp_error),
        .copro_valid    (copro_valid),
        .copro_opcode   (copro_opcode),
        .copro_op0      (copro_op0),
        .copro_op1      (copro_op1),
        .copro_accept   (copro_accept),
        .copro_complete (copro_complete),
        .copro_result   (copro_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Coprocessor results for the operand pairs used below, hand-computed.
    function automatic logic [31:0] copro_ref(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == OP_DIV && a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        if (op == OP_SUB) return 32'h0;
        return 32'hDEADBEEF;
    endfunction

    function automatic int copro_lat(input logic [10:0] op);
        case (op)
            OP_ADD, OP_SUB: return 2;
            OP_MUL:         return 3;
            default:        return 12;
        endcase
    endfunction

    always @(posedge clk) begin
        if (cp_busy) begin
            if (copro_complete && copro_accept) begin
                copro_complete <= 1'b0;
                cp_busy        <= 1'b0;
            end else if (cp_cnt > 0) begin
                cp_cnt <= cp_cnt - 1;
                if (cp_cnt == 1) copro_complete <= 1'b1;
            end
        end else if (copro_valid) begin
            cp_busy      <= 1'b1;
            cp_cnt       <= copro_lat(copro_opcode);
            copro_result <= copro_ref(copro_opcode, copro_op0, copro_op1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearCounters();
        t_ready = -100; t_cv = -100; t_acc = -100; t_rsp = -100;
        n_cv = 0; n_acc = 0; n_rv = 0;
    endtask

    // Observer: timestamps and event counts, plus the granted index sequence.
    always @(negedge clk) begin : obs
        int g;
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        if (g >= 0) begin
            t_ready = cyc;
            grant_q.push_back(g);
        end
        if (copro_valid)  begin t_cv  = cyc; n_cv++;  end
        if (copro_accept) begin t_acc = cyc; n_acc++; end
        if (rsp_valid != '0) begin
            if (!prev_rv) t_rsp = cyc;
            n_rv++;
        end
        prev_rv = (rsp_valid != '0);
    end

    // Monitor: every new response is compared against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rsp_valid != '0 && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_valid_index", 32'(rsp_valid), 32'(1 << e.idx));
                checkOutput("rsp_result", rsp_result, e.res);
                checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
            end
        end
        if (rsp_valid == '0) seen = 1'b0;
    end

    task automatic applyStimulus(input int idx, input logic [10:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int acc_delay);
        int n;
        @(posedge clk); #1;
        req_valid[idx]  = 1'b1;
        req_opcode[idx] = op;
        req_op0[idx]    = a;
        req_op1[idx]    = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[idx] && n < 200);
        checkOutput("req_ready_wait", 32'(req_ready[idx]), 32'h1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        n = 0;
        while (!rsp_valid[idx] && n < 200) begin @(negedge clk); n++; end
        checkOutput("rsp_valid_wait", 32'(rsp_valid[idx]), 32'h1);
        repeat (acc_delay) @(negedge clk);
        rsp_accept[idx] = 1'b1;
        @(posedge clk); #1;
        rsp_accept[idx] = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        reset_n = 1'b1;
        req_valid = '0; req_opcode = '0; req_op0 = '0; req_op1 = '0; rsp_accept = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready",    32'(req_ready),    32'h0);
        checkOutput("reset_rsp_valid",    32'(rsp_valid),    32'h0);
        checkOutput("reset_rsp_result",   rsp_result,        32'h0);
        checkOutput("reset_rsp_error",    32'(rsp_error),    32'h0);
        checkOutput("reset_copro_valid",  32'(copro_valid),  32'h0);
        checkOutput("reset_copro_accept", 32'(copro_accept), 32'h0);
        checkOutput("reset_copro_opcode", 32'(copro_opcode), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;

        $display("[TB] add on requester 0");
        clearCounters();
        sb.push_back('{0, 32'h40700000, 1'b0});
        applyStimulus(0, OP_ADD, 32'h3FC00000, 32'h40100000, 0);
        checkOutput("add_copro_valid_lat", 32'(t_cv - t_ready), 32'd1);
        checkOutput("add_rsp_lat",         32'(t_rsp - t_acc),  32'd1);
        checkOutput("add_accept_cycles",   32'(n_acc),          32'd1);

        $display("[TB] div on requester 2, slow accept");
        clearCounters();
        sb.push_back('{2, 32'h3E800000, 1'b0});
        applyStimulus(2, OP_DIV, 32'h3F800000, 32'h40800000, 4);
        checkOutput("div_accept_cycles",   32'(n_acc), 32'd1);
        checkOutput("div_rsp_held_cycles", 32'(n_rv),  32'd5);
        checkOutput("div_copro_valid_cnt", 32'(n_cv),  32'd1);

        $display("[TB] illegal opcode on requester 1");
        clearCounters();
        sb.push_back('{1, 32'h0, 1'b1});
        applyStimulus(1, 11'd7, 32'h12345678, 32'h9ABCDEF0, 0);
        checkOutput("illegal_rsp_lat",   32'(t_rsp - t_ready), 32'd1);
        checkOutput("illegal_copro_cnt", 32'(n_cv),            32'd0);
        checkOutput("illegal_rsp_cycles", 32'(n_rv),           32'd1);

        $display("[TB] foreign rsp_accept ignored");
        clearCounters();
        sb.push_back('{1, 32'h40700000, 1'b0});
        fork
            applyStimulus(1, OP_ADD, 32'h3FC00000, 32'h40100000, 3);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 200);
                rsp_accept[3] = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("ignore_other_accept", 32'(rsp_valid), 32'h2);
                end
                rsp_accept[3] = 1'b0;
            end
        join

        $display("[TB] reset during div wait");
        clearCounters();
        @(posedge clk); #1;
        req_valid[2] = 1'b1; req_opcode[2] = OP_DIV;
        req_op0[2] = 32'h3F800000; req_op1[2] = 32'h40800000;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[2] && n < 50);
        checkOutput("abort_req_ready", 32'(req_ready[2]), 32'h1);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("abort_rsp_result",   rsp_result,        32'h0);
        checkOutput("abort_copro_op0",    copro_op0,         32'h0);
        checkOutput("abort_copro_opcode", 32'(copro_opcode), 32'h0);
        checkOutput("abort_rsp_valid",    32'(rsp_valid),    32'h0);
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1;
        clearCounters();
        n = 0;
        do begin @(negedge clk); n++; end while (!copro_complete && n < 50);
        do begin @(negedge clk); n++; end while (copro_complete && n < 100);
        checkOutput("drain_accept_cycles", 32'(n_acc), 32'd1);
        checkOutput("drain_no_rsp",        32'(n_rv),  32'd0);

        $display("[TB] all requesters, continuous mul");
        clearCounters();
        grant_q.delete();
        for (int i = 0; i < 5; i++) sb.push_back('{exp_order[i], 32'h40C00000, 1'b0});
        fork
            begin
                applyStimulus(0, OP_MUL, 32'h40000000, 32'h40400000, 0);
                applyStimulus(0, OP_MUL, 32'h40000000, 32'h40400000, 0);
            end
            applyStimulus(1, OP_MUL, 32'h40000000, 32'h40400000, 0);
            applyStimulus(2, OP_MUL, 32'h40000000, 32'h40400000, 0);
            applyStimulus(3, OP_MUL, 32'h40000000, 32'h40400000, 0);
        join
        checkOutput("grant_count", 32'(grant_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("grant_order_%0d", i),
                        32'((i < grant_q.size()) ? grant_q[i] : -1), 32'(exp_order[i]));
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/float_copro_arbiter.md
Name: float_copro_arbiter

Overview:
- Shares one float_copro instance between N requesters using round-robin arbitration.
- Forwards one command at a time over the copro valid/accept/complete handshake.
- Returns the result to the requester that issued the command.
- Rejects opcodes the coprocessor does not implement, since those would never complete.
- Drains stale completions left after the arbiter is reset.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, $clog2(N), requester index width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  requester i has a command pending; held until req_ready[i].
- req_opcode  in  N x 11  per-requester opcode (0 add, 1 sub, 2 mul, 3 div).
- req_op0  in  N x 32  per-requester operand 0 (IEEE-754 single).
- req_op1  in  N x 32  per-requester operand 1.
- req_ready  out  N  one-cycle pulse: command of requester i taken.
- rsp_valid  out  N  result available for requester i; held until rsp_accept[i].
- rsp_accept  in  N  requester i consumes the response.
- rsp_result  out  32  shared result bus, meaningful while any rsp_valid is high.
- rsp_error  out  1  1 = illegal opcode, result forced to 0.
- copro_valid  out  1  to coprocessor.
- copro_opcode  out  11  to coprocessor.
- copro_op0  out  32  to coprocessor.
- copro_op1  out  32  to coprocessor.
- copro_accept  out  1  to coprocessor.
- copro_complete  in  1  from coprocessor.
- copro_result  in  32  from coprocessor.

Behaviour:
- Reset (async assert, sync release) clears: state=IDLE, rr_ptr=N-1.
- Reset also clears all outputs to 0: req_ready, rsp_valid, rsp_result, rsp_error, copro_valid, copro_accept, copro_opcode, copro_op0, copro_op1.
- IDLE, copro_complete=1:
  - Stale completion from before reset; assert copro_accept combinationally and discard copro_result.
  - No grant in that cycle.
- IDLE, copro_complete=0, any req_valid:
  - Grant the first set bit searching from rr_ptr+1 with wrap to 0; rr_ptr <= granted index.
  - Pulse req_ready[g] for one cycle.
  - Register opcode and operands; store g.
  - If opcode>3: go to RESP with rsp_error=1, rsp_result=0, copro untouched.
  - Otherwise: go to ISSUE.
- ISSUE:
  - copro_valid=1 for exactly one cycle, with the registered opcode and operands (coprocessor samples here).
  - Next state is WAIT.
- WAIT:
  - copro_valid=0.
  - On copro_complete=1: copro_accept=1 combinationally that cycle, capture copro_result into rsp_result, rsp_error=0, go to RESP.
- RESP:
  - rsp_valid[g]=1 (registered, so first high on the cycle after capture).
  - Other bits of rsp_valid stay 0.
  - On rsp_accept[g]: rsp_valid cleared next edge, go to IDLE.
  - rsp_accept for other indices is ignored.
- Latency, legal opcode, arbiter side: req_ready at cycle 0, copro_valid at cycle 1, rsp_valid at cycle (cycle of copro_complete)+1.
- Latency, illegal opcode: rsp_valid at cycle 1.
- Only one command is outstanding at a time; req_valid from others is held off with req_ready=0.
- Simultaneous req_valid from all requesters with continuous traffic: grants rotate 0,1,2,3,0,… and no requester is starved.
- Requester dropping req_valid before req_ready is a protocol violation; behaviour is unspecified.
- rsp_accept asserted in the same cycle rsp_valid rises is legal; the response lasts one cycle.
- Reset mid-ISSUE or mid-WAIT: the arbiter returns to IDLE and the in-flight result is drained by the IDLE rule. No rsp_valid is produced for the aborted command.

Decomposition:
- Package float_copro_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - OP_MAX=3;
  - enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: rr_pick (combinational round-robin picker).
  - Inputs: req vector, pointer.
  - Outputs: grant index, any-grant flag.

Test Plan:
- Requester 0, op 0, 0x3FC00000 + 0x40100000 (t_add=2) -> req_ready[0] at cycle 0, copro_valid at cycle 1, rsp_valid[0] with rsp_result=0x40700000, rsp_error=0.
- Requester 2, op 3, 0x3F800000 / 0x40800000 (t_div=12) -> rsp_result=0x3E800000. copro_accept is high for exactly one cycle, and rsp_valid is held 5 cycles until rsp_accept[2].
- All 4 requesters assert op 2, 0x40000000 * 0x40400000 continuously -> grant order 0,1,2,3,0; every response is 0x40C00000 to the matching index only.
- Requester 1, opcode 11'd7 -> rsp_valid[1] at cycle 1, rsp_error=1, rsp_result=0, copro_valid never asserted.
- reset_n pulsed low during WAIT of a div -> outputs 0 immediately. On later copro_complete in IDLE: copro_accept pulses, no rsp_valid, the next request is served normally.
- rsp_accept[3] asserted while rsp_valid[1] is high -> ignored; state stays RESP until rsp_accept[1].
